// File: rtl/spi_gain_ctrl.sv
// SPI mode-0 slave that turns 16-bit {address, gain} frames into single-cycle
// writes to the band-gain register map. Frames whose address is out of range
// raise addr_err instead of writing. A frame cut short by cs_n rising raises
// frame_err.
module spi_gain_ctrl #(
    parameter int unsigned NumBands  = 10,
    parameter int unsigned AddrWidth = 8,
    parameter int unsigned DataWidth = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 sclk_i,
    input  logic                 cs_n_i,
    input  logic                 mosi_i,
    output logic                 we_o,
    output logic [AddrWidth-1:0] wr_addr_o,
    output logic [DataWidth-1:0] wr_data_o,
    output logic                 busy_o,
    output logic                 frame_err_o,
    output logic                 addr_err_o
);

    typedef enum logic [1:0] {StIdle, StAddr, StData} state_e;

    // Synchronizers, edge-detect history and post-reset warm-up counter
    logic       sclk_meta_q, sclk_s_q, sclk_q;
    logic       cs_meta_q, cs_s_q, cs_q;
    logic       mosi_meta_q, mosi_s_q;
    logic [1:0] warm_q;

    // Frame FSM and output registers
    state_e               state_q, state_d;
    logic [3:0]           bit_cnt_q, bit_cnt_d;
    logic [7:0]           shift_q, shift_d;
    logic [7:0]           addr_byte_q, addr_byte_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [DataWidth-1:0] wr_data_q, wr_data_d;
    logic                 frame_err_q, frame_err_d;
    logic                 addr_err_q, addr_err_d;

    logic       edges_ok;
    logic       sclk_rise, cs_fall, cs_rise;
    logic [7:0] shift_next;

    // Double-flop the SPI pins and keep one more stage for edge detection
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sclk_meta_q <= 1'b0;
            sclk_s_q    <= 1'b0;
            sclk_q      <= 1'b0;
            cs_meta_q   <= 1'b1;
            cs_s_q      <= 1'b1;
            cs_q        <= 1'b1;
            mosi_meta_q <= 1'b0;
            mosi_s_q    <= 1'b0;
            warm_q      <= 2'd0;
        end else begin
            sclk_meta_q <= sclk_i;
            sclk_s_q    <= sclk_meta_q;
            sclk_q      <= sclk_s_q;
            cs_meta_q   <= cs_n_i;
            cs_s_q      <= cs_meta_q;
            cs_q        <= cs_s_q;
            mosi_meta_q <= mosi_i;
            mosi_s_q    <= mosi_meta_q;
            if (warm_q != 2'd3) begin
                warm_q <= warm_q + 2'd1;
            end
        end
    end

    // Edges count only once the whole pipeline holds real pin samples, so a
    // cs_n already low at reset release never looks like a falling edge.
    assign edges_ok   = (warm_q == 2'd3);
    assign sclk_rise  = edges_ok & sclk_s_q & ~sclk_q;
    assign cs_fall    = edges_ok & cs_q & ~cs_s_q;
    assign cs_rise    = edges_ok & ~cs_q & cs_s_q;
    assign shift_next = {shift_q[6:0], mosi_s_q};

    // Next-state logic: shift bits, latch address, issue write or error pulse
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        addr_byte_d = addr_byte_q;
        we_d        = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        frame_err_d = 1'b0;
        addr_err_d  = 1'b0;

        case (state_q)
            StIdle: begin
                if (cs_fall) begin
                    state_d   = StAddr;
                    bit_cnt_d = 4'd0;
                    shift_d   = 8'd0;
                end
            end
            StAddr: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        addr_byte_d = shift_next;
                        state_d     = StData;
                    end
                end
            end
            StData: begin
                if (sclk_rise) begin
                    shift_d   = shift_next;
                    bit_cnt_d = bit_cnt_q + 4'd1;  // wraps to 0 on the 16th bit
                    if (bit_cnt_q == 4'd15) begin
                        if (32'(addr_byte_q) < NumBands) begin
                            we_d      = 1'b1;
                            wr_addr_d = AddrWidth'(addr_byte_q);
                            wr_data_d = DataWidth'(shift_next);
                        end else begin
                            addr_err_d = 1'b1;
                        end
                        state_d = StAddr;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        // cs_n rising wins over everything but a frame completing this cycle
        if (cs_rise && (state_q != StIdle)) begin
            frame_err_d = (bit_cnt_d != 4'd0);
            state_d     = StIdle;
            bit_cnt_d   = 4'd0;
            shift_d     = 8'd0;
        end
    end

    // FSM state and registered outputs
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            bit_cnt_q   <= 4'd0;
            shift_q     <= 8'd0;
            addr_byte_q <= 8'd0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            frame_err_q <= 1'b0;
            addr_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            addr_byte_q <= addr_byte_d;
            we_q        <= we_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            frame_err_q <= frame_err_d;
            addr_err_q  <= addr_err_d;
        end
    end

    assign we_o        = we_q;
    assign wr_addr_o   = wr_addr_q;
    assign wr_data_o   = wr_data_q;
    assign busy_o      = (state_q != StIdle);
    assign frame_err_o = frame_err_q;
    assign addr_err_o  = addr_err_q;

endmodule

// File: tb/tb_spi_gain_ctrl.sv
// Bench for spi_gain_ctrl: drives SPI frames on the pins, logs every write and
// error pulse, and compares against a frame-level model of the register map.
module tb_spi_gain_ctrl;

    localparam int unsigned NUM_BANDS = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk = 1'b0;
    logic       cs_n = 1'b1;
    logic       mosi = 1'b0;
    logic       we;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;
    logic       frame_err;
    logic       addr_err;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed activity
    logic [15:0] we_log[$];
    int          fe_cnt  = 0;
    int          ae_cnt  = 0;
    int          we_dbl  = 0;
    logic        we_prev = 1'b0;

    // Frame-level model of the register map
    logic [15:0] exp_log[$];
    logic [7:0]  exp_addr = 8'h00;
    logic [7:0]  exp_data = 8'h00;
    int          exp_ae   = 0;

    spi_gain_ctrl #(
        .NumBands (NUM_BANDS),
        .AddrWidth(8),
        .DataWidth(8)
    ) dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sclk_i     (sclk),
        .cs_n_i     (cs_n),
        .mosi_i     (mosi),
        .we_o       (we),
        .wr_addr_o  (wr_addr),
        .wr_data_o  (wr_data),
        .busy_o     (busy),
        .frame_err_o(frame_err),
        .addr_err_o (addr_err)
    );

    always #5 clk = ~clk;

    // Monitor on the falling edge, away from the DUT's active edge
    always @(negedge clk) begin
        if (we) begin
            we_log.push_back({wr_addr, wr_data});
            if (we_prev) we_dbl <= we_dbl + 1;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (addr_err) ae_cnt <= ae_cnt + 1;
        we_prev <= we;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bit(input logic b);
        mosi = b;
        wait_clks(4);
        sclk = 1'b1;
        wait_clks(4);
        sclk = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] d);
        logic [15:0] w;
        w = {a, d};
        for (int i = 15; i >= 0; i--) spi_bit(w[i]);
    endtask

    task automatic cs_low();
        cs_n = 1'b0;
        wait_clks(4);
    endtask

    task automatic cs_high();
        wait_clks(4);
        cs_n = 1'b1;
        wait_clks(8);
    endtask

    // Reference: a complete frame writes iff the address names a real band
    task automatic model_frame(input logic [7:0] a, input logic [7:0] d);
        if (int'(a) < NUM_BANDS) begin
            exp_log.push_back({a, d});
            exp_addr = a;
            exp_data = d;
        end else begin
            exp_ae++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_clks(3);
        n_checks++;
        if ({we, wr_addr, wr_data, busy, frame_err, addr_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b fe=%b ae=%b, want all 0",
                     we, wr_addr, wr_data, busy, frame_err, addr_err);
        end
        rst_n = 1'b1;
        wait_clks(6);
    endtask

    task automatic test_single();
        int wb = we_log.size();
        int fb = fe_cnt;
        int ab = ae_cnt;
        cs_low();
        send_frame(8'h03, 8'h80);
        model_frame(8'h03, 8'h80);
        cs_high();
        n_checks++;
        if (we_log.size() - wb !== 1) begin
            n_fail++;
            $display("FAIL single_we_count: got %0d, want 1", we_log.size() - wb);
        end else begin
            n_checks++;
            if (we_log[wb] !== 16'h0380) begin
                n_fail++;
                $display("FAIL single_write: got %h, want 0380", we_log[wb]);
            end
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_busy_after: got %b, want 0", busy);
        end
        n_checks++;
        if ((fe_cnt - fb) + (ae_cnt - ab) !== 0) begin
            n_fail++;
            $display("FAIL single_no_errors: got fe=%0d ae=%0d, want 0 0", fe_cnt - fb, ae_cnt - ab);
        end
    endtask

    task automatic test_stream();
        int wb = we_log.size();
        cs_low();
        send_frame(8'h00, 8'h10);
        model_frame(8'h00, 8'h10);
        wait_clks(2);
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_busy_between: got %b, want 1", busy);
        end
        send_frame(8'h09, 8'hFF);
        model_frame(8'h09, 8'hFF);
        cs_high();
        n_checks++;
        if (we_log.size() - wb !== 2) begin
            n_fail++;
            $display("FAIL stream_we_count: got %0d, want 2", we_log.size() - wb);
        end else begin
            n_checks++;
            if ({we_log[wb], we_log[wb+1]} !== 32'h0010_09FF) begin
                n_fail++;
                $display("FAIL stream_writes: got %h %h, want 0010 09ff", we_log[wb], we_log[wb+1]);
            end
        end
    endtask

    task automatic test_bad_addr();
        int wb = we_log.size();
        int ab = ae_cnt;
        cs_low();
        send_frame(8'h0A, 8'h55);
        model_frame(8'h0A, 8'h55);
        wait_clks(2);
        n_checks++;
        if (ae_cnt - ab !== 1 || we_log.size() !== wb) begin
            n_fail++;
            $display("FAIL bad_addr_pulse: got ae=%0d we=%0d, want 1 0", ae_cnt - ab, we_log.size() - wb);
        end
        n_checks++;
        if ({wr_addr, wr_data} !== {exp_addr, exp_data}) begin
            n_fail++;
            $display("FAIL bad_addr_hold: got %h%h, want %h%h", wr_addr, wr_data, exp_addr, exp_data);
        end
        send_frame(8'h01, 8'h20);
        model_frame(8'h01, 8'h20);
        cs_high();
        n_checks++;
        if (we_log.size() - wb !== 1 || we_log[we_log.size()-1] !== 16'h0120) begin
            n_fail++;
            $display("FAIL bad_addr_next: got count %0d last %h, want 1 0120",
                     we_log.size() - wb, we_log[we_log.size()-1]);
        end
    endtask

    task automatic test_abort();
        int wb = we_log.size();
        int fb = fe_cnt;
        cs_low();
        for (int i = 0; i < 11; i++) spi_bit(1'($urandom_range(0, 1)));
        cs_high();
        n_checks++;
        if (fe_cnt - fb !== 1 || we_log.size() !== wb) begin
            n_fail++;
            $display("FAIL abort_pulse: got fe=%0d we=%0d, want 1 0", fe_cnt - fb, we_log.size() - wb);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_busy: got %b, want 0", busy);
        end
        cs_low();
        send_frame(8'h02, 8'h40);
        model_frame(8'h02, 8'h40);
        cs_high();
        n_checks++;
        if (we_log.size() - wb !== 1 || we_log[we_log.size()-1] !== 16'h0240) begin
            n_fail++;
            $display("FAIL abort_next: got count %0d last %h, want 1 0240",
                     we_log.size() - wb, we_log[we_log.size()-1]);
        end
    endtask

    task automatic test_reset_mid();
        int wb;
        int fb = fe_cnt;
        cs_low();
        for (int i = 0; i < 5; i++) spi_bit(1'b1);
        rst_n = 1'b0;
        wait_clks(2);
        n_checks++;
        if ({we, wr_addr, wr_data, busy, frame_err, addr_err} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got we=%b addr=%h data=%h busy=%b fe=%b ae=%b, want all 0",
                     we, wr_addr, wr_data, busy, frame_err, addr_err);
        end
        rst_n = 1'b1;
        exp_addr = 8'h00;
        exp_data = 8'h00;
        wb = we_log.size();
        send_frame(8'h05, 8'h66);  // cs_n never toggled: must be ignored
        wait_clks(4);
        n_checks++;
        if (we_log.size() !== wb || fe_cnt !== fb || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_ignore: got we=%0d fe=%0d busy=%b, want 0 0 0",
                     we_log.size() - wb, fe_cnt - fb, busy);
        end
        cs_n = 1'b1;
        wait_clks(8);
        cs_low();
        send_frame(8'h04, 8'h33);
        model_frame(8'h04, 8'h33);
        cs_high();
        n_checks++;
        if (we_log.size() - wb !== 1 || we_log[we_log.size()-1] !== 16'h0433 || fe_cnt !== fb) begin
            n_fail++;
            $display("FAIL reset_mid_next: got count %0d last %h fe=%0d, want 1 0433 0",
                     we_log.size() - wb, we_log[we_log.size()-1], fe_cnt - fb);
        end
    endtask

    task automatic test_boundary();
        int wb = we_log.size();
        int fb = fe_cnt;
        logic [15:0] w = 16'h07C0;
        cs_low();
        for (int i = 15; i >= 1; i--) spi_bit(w[i]);
        mosi = w[0];
        wait_clks(4);
        sclk = 1'b1;
        cs_n = 1'b1;  // same pin instant as the 16th sclk rise
        model_frame(8'h07, 8'hC0);
        wait_clks(4);
        sclk = 1'b0;
        wait_clks(8);
        n_checks++;
        if (we_log.size() - wb !== 1 || we_log[we_log.size()-1] !== 16'h07C0) begin
            n_fail++;
            $display("FAIL boundary_write: got count %0d last %h, want 1 07c0",
                     we_log.size() - wb, we_log[we_log.size()-1]);
        end
        n_checks++;
        if (fe_cnt !== fb || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL boundary_no_err: got fe=%0d busy=%b, want 0 0", fe_cnt - fb, busy);
        end
    endtask

    task automatic test_random();
        int lb = we_log.size();
        int eb = exp_log.size();
        int ab = ae_cnt;
        int ab_exp = exp_ae;
        for (int t = 0; t < 6; t++) begin
            int nf = $urandom_range(1, 3);
            cs_low();
            for (int f = 0; f < nf; f++) begin
                logic [7:0] a = 8'($urandom_range(0, 15));
                logic [7:0] d = 8'($urandom);
                send_frame(a, d);
                model_frame(a, d);
            end
            cs_high();
        end
        n_checks++;
        if (we_log.size() - lb !== exp_log.size() - eb) begin
            n_fail++;
            $display("FAIL random_we_count: got %0d, want %0d", we_log.size() - lb, exp_log.size() - eb);
        end else begin
            for (int i = 0; i < exp_log.size() - eb; i++) begin
                n_checks++;
                if (we_log[lb+i] !== exp_log[eb+i]) begin
                    n_fail++;
                    $display("FAIL random_write[%0d]: got %h, want %h", i, we_log[lb+i], exp_log[eb+i]);
                end
            end
        end
        n_checks++;
        if (ae_cnt - ab !== exp_ae - ab_exp) begin
            n_fail++;
            $display("FAIL random_addr_err: got %0d, want %0d", ae_cnt - ab, exp_ae - ab_exp);
        end
        n_checks++;
        if ({wr_addr, wr_data} !== {exp_addr, exp_data}) begin
            n_fail++;
            $display("FAIL random_final_regs: got %h%h, want %h%h", wr_addr, wr_data, exp_addr, exp_data);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_stream();
        test_bad_addr();
        test_abort();
        test_reset_mid();
        test_boundary();
        test_random();
        n_checks++;
        if (we_dbl !== 0) begin
            n_fail++;
            $display("FAIL we_single_cycle: got %0d multi-cycle strobes, want 0", we_dbl);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
